// File: rtl/swt_debounce_sync.sv
// Slide-switch conditioner: two-flop synchroniser, per-channel debounce,
// rise/fall pulses and a latest-value valid/ready change-event channel.
module swt_debounce_sync #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned DEBOUNCE_CNT = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] swt_in,
  output logic [WIDTH-1:0] swt_db,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_data,
  input  logic             evt_ready,
  output logic             evt_overrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  typedef enum logic {
    EVT_IDLE = 1'b0,
    EVT_PEND = 1'b1
  } evt_state_t;

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_evt_data;
  logic             r_evt_overrun;
  evt_state_t       r_evt_state;

  logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_db_nxt;
  logic             w_change;
  evt_state_t       w_evt_state_nxt;
  logic [WIDTH-1:0] w_evt_data_nxt;
  logic             w_evt_overrun_nxt;

  // Two-flop synchroniser; only r_s2 is used downstream.
  always_ff @(posedge clk) begin
    if (rstb) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= swt_in;
      r_s2 <= r_s1;
    end
  end

  // Any cycle agreeing with the debounced level restarts that channel's count.
  always_comb begin
    w_db_nxt = r_db;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (r_s2[i] == r_db[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        w_db_nxt[i]  = r_s2[i];
        w_cnt_nxt[i] = '0;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  assign w_change = |(w_db_nxt ^ r_db);

  always_ff @(posedge clk) begin
    if (rstb) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= '0;
      end
      r_db   <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_db   <= w_db_nxt;
      r_rise <= w_db_nxt & ~r_db;
      r_fall <= r_db & ~w_db_nxt;
    end
  end

  // Event channel state register.
  always_ff @(posedge clk) begin
    if (rstb) begin
      r_evt_state   <= EVT_IDLE;
      r_evt_data    <= '0;
      r_evt_overrun <= 1'b0;
    end else begin
      r_evt_state   <= w_evt_state_nxt;
      r_evt_data    <= w_evt_data_nxt;
      r_evt_overrun <= w_evt_overrun_nxt;
    end
  end

  // A change arriving with an accept keeps the slot full without losing anything.
  always_comb begin
    w_evt_state_nxt   = r_evt_state;
    w_evt_data_nxt    = r_evt_data;
    w_evt_overrun_nxt = r_evt_overrun;
    case (r_evt_state)
      EVT_IDLE: begin
        if (w_change) begin
          w_evt_state_nxt = EVT_PEND;
          w_evt_data_nxt  = w_db_nxt;
        end
      end
      EVT_PEND: begin
        if (evt_ready) begin
          w_evt_overrun_nxt = 1'b0;
          if (w_change) begin
            w_evt_data_nxt = w_db_nxt;
          end else begin
            w_evt_state_nxt = EVT_IDLE;
          end
        end else if (w_change) begin
          w_evt_data_nxt    = w_db_nxt;
          w_evt_overrun_nxt = 1'b1;
        end
      end
      default: begin
        w_evt_state_nxt = EVT_IDLE;
      end
    endcase
  end

  assign swt_db      = r_db;
  assign rise        = r_rise;
  assign fall        = r_fall;
  assign evt_valid   = (r_evt_state == EVT_PEND);
  assign evt_data    = r_evt_data;
  assign evt_overrun = r_evt_overrun;

endmodule

// File: doc/swt_debounce_sync.md
Name: swt_debounce_sync

Overview:
- Input-side conditioner for the board slide switches: the switch-to-logic path that the LED output side consumes.
- Synchronises raw asynchronous switch inputs to `clk` and debounces each channel independently.
- Emits one-cycle rise/fall pulses per channel.
- Presents every debounced change as a valid/ready event carrying the new switch vector. Sits between the `swt` pins and the LED/pattern controller.

Parameters:
- WIDTH, 4: number of switch channels.
- DEBOUNCE_CNT, 16: consecutive cycles the synchronised input must differ from the debounced level before the level flips. Legal values are 1 or more.
- CNT_W, 16: debounce counter width. Must be able to hold DEBOUNCE_CNT-1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rstb  input  1  reset, synchronous and active-high.
- swt_in  input  WIDTH  raw asynchronous switch levels.
- swt_db  output  WIDTH  debounced switch levels.
- rise  output  WIDTH  one-cycle pulse per channel on a 0->1 debounced transition.
- fall  output  WIDTH  one-cycle pulse per channel on a 1->0 debounced transition.
- evt_valid  output  1  change event pending.
- evt_data  output  WIDTH  swt_db value of the most recent change.
- evt_ready  input  1  consumer accepts the event when evt_valid is also high.
- evt_overrun  output  1  sticky flag: a pending event was overwritten before it was accepted.

Behaviour:
- Reset:
  - While rstb=1 at a rising edge, all of the following clear to 0: sync stages, counters, swt_db, rise, fall, evt_valid, evt_data, evt_overrun.
  - Reset mid-debounce discards partial counts.
  - After reset, any input held at 1 re-debounces from 0 and produces a normal rise and event.
- Synchroniser:
  - Two flops per channel: s1 <= swt_in, s2 <= s1.
  - Only s2 is used downstream.
- Debounce, per channel, independent:
  - If s2 == swt_db[i], cnt[i] <= 0.
  - Otherwise, if cnt[i] == DEBOUNCE_CNT-1: swt_db[i] <= s2, cnt[i] <= 0.
  - Otherwise, cnt[i] <= cnt[i]+1.
  - Any single cycle with s2 equal to swt_db restarts the count, so glitches shorter than DEBOUNCE_CNT synchronised cycles are suppressed.
- Latency:
  - A clean step on swt_in, first captured at edge E, appears on swt_db after edge E+DEBOUNCE_CNT+1, i.e. it is visible in cycle E+DEBOUNCE_CNT+2.
  - With DEBOUNCE_CNT=1 the flip happens one edge after s2 first differs.
- Edge pulses:
  - rise/fall are registered and high for exactly the one cycle in which the new swt_db value first appears.
  - Multiple channels may pulse in the same cycle.
- Event channel:
  - `change` = any swt_db bit flips at this edge. evt_data always captures the new swt_db.
  - change with evt_valid=0: evt_valid <= 1, evt_data <= new swt_db.
  - evt_valid=1 and evt_ready=1, no change: evt_valid <= 0, evt_overrun <= 0.
  - evt_valid=1 and evt_ready=1 with change in the same edge: evt_valid stays 1, evt_data <= new value, evt_overrun <= 0 (the old event was accepted, so nothing was lost).
  - evt_valid=1, evt_ready=0 with change: evt_data <= new value (latest-value semantics), evt_overrun <= 1.
  - evt_overrun stays 1 until the next accepting handshake.
  - Apart from the overwrite case, evt_data holds stable while evt_valid=1.
  - evt_ready is ignored while evt_valid=0.
- No combinational path from swt_in or evt_ready to any output.

Test Plan (DEBOUNCE_CNT=16, 8 ns clk):
1. Hold swt_in=4'b1111 with rstb=1 for 10 cycles, then release:
   - All outputs stay 0 during reset.
   - swt_db becomes 4'b1111 on the 18th cycle after release.
   - rise=4'b1111 for exactly 1 cycle; evt_valid=1, evt_data=4'b1111.
2. swt_in[0] high for 10 cycles then low, evt_ready=1:
   - swt_db, rise, fall and evt_valid never assert.
3. swt_in[1] toggles every 3 cycles for 30 cycles, then stays 1:
   - Exactly one rise[1] pulse, 18 cycles after the final toggle.
   - Exactly one event, evt_data=4'b0010.
4. evt_ready=0; debounced change to 4'b0001, then to 4'b0011:
   - evt_data=4'b0011, evt_overrun=1.
   - Pulse evt_ready for 1 cycle: evt_valid=0 and evt_overrun=0 next cycle.
5. Pending event (4'b0100) with evt_ready=1 in the same cycle that swt_db flips to 4'b1000:
   - evt_valid remains 1, evt_data=4'b1000, evt_overrun=0, fall[2] and rise[3] each pulse once.
6. Step swt_in to 4'b1001, assert rstb for 1 cycle when cnt reaches 8, hold input:
   - swt_db stays 0 through the reset.
   - The flip to 4'b1001 occurs 18 cycles after reset release.
   - rise=4'b1001 for 1 cycle, one event.
